// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass, per-register busy scoreboard,
// x0 write-error pulse, trigger load of a fixed register and a stored-value probe output.
module regfile_mp #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned NUM_WRITE  = 1,
  parameter bit          BYPASS     = 1'b1,
  parameter int unsigned TRIG_REG   = 17,
  parameter int unsigned PROBE_REG  = 10
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   i_raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   o_rdata,
  output logic [NUM_READ-1:0]              o_rbusy,
  input  logic [NUM_WRITE-1:0]             i_wen,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  i_waddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  i_wdata,
  input  logic                             i_rsv_en,
  input  logic [ADDR_WIDTH-1:0]            i_rsv_addr,
  input  logic                             i_trigger,
  output logic [DATA_WIDTH-1:0]            o_a0,
  output logic [(2**ADDR_WIDTH)-1:0]       o_busy_vec,
  output logic                             o_x0_wr_err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TrigIdx  = ADDR_WIDTH'(TRIG_REG);
  localparam logic [ADDR_WIDTH-1:0] ProbeIdx = ADDR_WIDTH'(PROBE_REG);

  logic [DATA_WIDTH-1:0] r_regs [Depth];
  logic [Depth-1:0]      r_busy;
  logic                  r_x0_err;

  logic [ADDR_WIDTH-1:0] w_waddr [NUM_WRITE];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_WRITE];
  logic [ADDR_WIDTH-1:0] w_raddr [NUM_READ];
  logic [Depth-1:0]      w_busy_d;
  logic                  w_x0_wr;

  always_comb begin
    for (int j = 0; j < NUM_WRITE; j++) begin
      w_waddr[j] = i_waddr[j*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata[j] = i_wdata[j*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < NUM_READ; i++) begin
      w_raddr[i] = i_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Writeback clears first so a same-cycle reservation of the same register leaves it busy.
  always_comb begin
    w_busy_d = r_busy;
    w_x0_wr  = 1'b0;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (i_wen[j]) begin
        if (w_waddr[j] == '0) w_x0_wr = 1'b1;
        else                  w_busy_d[w_waddr[j]] = 1'b0;
      end
    end
    if (i_rsv_en && (i_rsv_addr != '0)) w_busy_d[i_rsv_addr] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int n = 0; n < Depth; n++) r_regs[n] <= '0;
      r_busy   <= '0;
      r_x0_err <= 1'b0;
    end else begin
      if (i_trigger) r_regs[TrigIdx] <= DATA_WIDTH'(1);
      // Ascending port order: the highest enabled port to an address lands last and wins.
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (i_wen[j] && (w_waddr[j] != '0)) r_regs[w_waddr[j]] <= w_wdata[j];
      end
      r_busy   <= w_busy_d;
      r_x0_err <= w_x0_wr;
    end
  end

  always_comb begin
    o_rdata = '0;
    o_rbusy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      o_rdata[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_raddr[i]];
      o_rbusy[i] = r_busy[w_raddr[i]];
      if (BYPASS) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (i_wen[j] && (w_waddr[j] == w_raddr[i])) begin
            o_rdata[i*DATA_WIDTH +: DATA_WIDTH] = w_wdata[j];
            o_rbusy[i] = (i_rsv_en && (i_rsv_addr == w_raddr[i])) ? r_busy[w_raddr[i]] : 1'b0;
          end
        end
      end
      if (w_raddr[i] == '0) begin
        o_rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        o_rbusy[i] = 1'b0;
      end
    end
  end

  assign o_a0        = r_regs[ProbeIdx];
  assign o_busy_vec  = r_busy;
  assign o_x0_wr_err = r_x0_err;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a two-write bypassing instance plus a single-write
// non-bypassing instance sharing port-0 stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        trigger;
  logic [31:0] a0;
  logic [31:0] busy_vec;
  logic        x0_err;

  logic [31:0] b_rdata;
  logic        b_rbusy;
  logic [31:0] b_a0;
  logic [31:0] b_busy_vec;
  logic        b_x0_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1'b1),
    .TRIG_REG(17), .PROBE_REG(10)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr), .o_rdata(rdata), .o_rbusy(rbusy),
    .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata), .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
    .i_trigger(trigger), .o_a0(a0), .o_busy_vec(busy_vec), .o_x0_wr_err(x0_err)
  );

  regfile_mp #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(1), .NUM_WRITE(1), .BYPASS(1'b0),
    .TRIG_REG(17), .PROBE_REG(10)
  ) u_dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_raddr(raddr[4:0]), .o_rdata(b_rdata), .o_rbusy(b_rbusy),
    .i_wen(wen[0]), .i_waddr(waddr[4:0]), .i_wdata(wdata[31:0]), .i_rsv_en(rsv_en),
    .i_rsv_addr(rsv_addr), .i_trigger(trigger), .o_a0(b_a0), .o_busy_vec(b_busy_vec),
    .o_x0_wr_err(b_x0_err)
  );

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  rsv_a;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ebusy;
    logic [31:0] enb;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    wen = 2'b00; waddr = '0; wdata = '0; rsv_en = 1'b0; rsv_addr = '0; trigger = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // wen, wa0, wd0, wa1, wd1, rsv, rsv_a, ra0, ra1, e0, e1, ebusy, e_nobypass
    vecs[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0,
                 32'hDEADBEEF, 32'h0, 2'b00, 32'h0};
    vecs[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd5,
                 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5,
                 32'h22, 32'hDEADBEEF, 2'b00, 32'h0};
    vecs[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd0,
                 32'h22, 32'h0, 2'b00, 32'h11};
    vecs[4]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd3,
                 32'h0, 32'h0, 2'b00, 32'h0};
    vecs[5]  = '{2'b10, 5'd0, 32'h0, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd5,
                 32'h33, 32'hDEADBEEF, 2'b01, 32'h0};
    vecs[6]  = '{2'b01, 5'd3, 32'h44, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd7,
                 32'h44, 32'h22, 2'b00, 32'h0};
    vecs[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 5'd3,
                 32'h44, 32'h44, 2'b00, 32'h44};
    vecs[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd0,
                 32'h0, 32'h0, 2'b00, 32'h0};
    vecs[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd9, 5'd3,
                 32'h0, 32'h44, 2'b01, 32'h0};
    vecs[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 5'd9,
                 32'h0, 32'h0, 2'b10, 32'h0};

    rst_n = 1'b0;
    raddr = '0;
    idle();
    repeat (2) tick();
    raddr = {5'd17, 5'd10};
    #1;
    chk("reset_rdata0", rdata[31:0], 32'h0);
    chk("reset_rdata1", rdata[63:32], 32'h0);
    chk("reset_busy_vec", busy_vec, 32'h0);
    chk("reset_x0_err", {31'b0, x0_err}, 32'h0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 11; k++) begin
      wen      = vecs[k].wen;
      waddr    = {vecs[k].wa1, vecs[k].wa0};
      wdata    = {vecs[k].wd1, vecs[k].wd0};
      rsv_en   = vecs[k].rsv;
      rsv_addr = vecs[k].rsv_a;
      raddr    = {vecs[k].ra1, vecs[k].ra0};
      #1;
      chk($sformatf("v%0d_rdata0", k), rdata[31:0], vecs[k].e0);
      chk($sformatf("v%0d_rdata1", k), rdata[63:32], vecs[k].e1);
      chk($sformatf("v%0d_rbusy", k), {30'b0, rbusy}, {30'b0, vecs[k].ebusy});
      chk($sformatf("v%0d_nobypass", k), b_rdata, vecs[k].enb);
      tick();
    end
    idle();
    #1;
    chk("busy_vec_only_x9", busy_vec, 32'h0000_0200);

    // x0 write is dropped and flagged for exactly one cycle
    wen = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'h55}; raddr = {5'd0, 5'd0};
    #1;
    chk("x0_read_during_wr", rdata[31:0], 32'h0);
    chk("x0_err_before", {31'b0, x0_err}, 32'h0);
    tick();
    idle();
    #1;
    chk("x0_err_pulse", {31'b0, x0_err}, 32'h1);
    chk("x0_read_after", rdata[31:0], 32'h0);
    tick();
    chk("x0_err_cleared", {31'b0, x0_err}, 32'h0);

    // Trigger vs write, then trigger alone, then a0 probe
    trigger = 1'b1; wen = 2'b01; waddr = {5'd0, 5'd17}; wdata = {32'h0, 32'h9};
    raddr = {5'd0, 5'd17};
    tick();
    idle();
    #1;
    chk("trig_wr_override", rdata[31:0], 32'h9);
    chk("trig_wr_override_nb", b_rdata, 32'h9);
    trigger = 1'b1;
    tick();
    idle();
    #1;
    chk("trig_alone", rdata[31:0], 32'h1);
    chk("trig_no_busy", busy_vec, 32'h0000_0200);
    wen = 2'b01; waddr = {5'd0, 5'd10}; wdata = {32'h0, 32'h42};
    #1;
    chk("a0_before_edge", a0, 32'h0);
    tick();
    idle();
    #1;
    chk("a0_after_edge", a0, 32'h42);
    chk("a0_after_edge_nb", b_a0, 32'h42);

    // Async reset mid-cycle with a write and reservation in flight
    wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'hAA}; rsv_en = 1'b1; rsv_addr = 5'd4;
    raddr = {5'd7, 5'd5};
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdata0", rdata[31:0], 32'h0);
    chk("async_rst_rdata1", rdata[63:32], 32'h0);
    chk("async_rst_busy_vec", busy_vec, 32'h0);
    chk("async_rst_a0", a0, 32'h0);
    tick();
    idle();
    rst_n = 1'b1;
    raddr = {5'd17, 5'd4};
    tick();
    chk("rst_lost_write", rdata[31:0], 32'h0);
    chk("rst_lost_rsv", busy_vec, 32'h0);
    chk("rst_x17", rdata[63:32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
